// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM for the multi-cycle datapath. It sequences
//               each instruction through fetch / decode / execute / memory /
//               write-back, and drives the datapath enables and mux selects.
//               It stalls on the memory ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] alu_funct_src,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_I_EXEC    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_SLTI  = 6'b001010;
  localparam logic [5:0] C_OP_ANDI  = 6'b001100;
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
  localparam logic [5:0] C_OP_XORI  = 6'b001110;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  // Moore control word; registered so outputs come straight from flops
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] alu_funct_src;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   w_fetch_ack;
  logic   w_store_ack;

  // Next-state logic: dispatch in DECODE, hold memory states until ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          C_OP_RTYPE:                                    state_d = S_R_EXEC;
          C_OP_LW, C_OP_SW:                              state_d = S_MEM_ADDR;
          C_OP_ADDI, C_OP_SLTI, C_OP_ANDI,
          C_OP_ORI, C_OP_XORI:                           state_d = S_I_EXEC;
          C_OP_BEQ:                                      state_d = S_BRANCH;
          C_OP_J:                                        state_d = S_JUMP;
          default:                                       state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == C_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_ALU_WB;
      S_I_EXEC:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ILLEGAL:   state_d = S_ILLEGAL;
      default:     state_d = S_IDLE;
    endcase
  end

  // Control word for the state being entered; opcode is already stable here
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = 2'b10;
      end
      S_I_EXEC: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = 2'b10;
        ctrl_d.alu_funct_src = 2'b01;
        case (opcode)
          C_OP_ADDI: ctrl_d.alu_op = 2'b00;
          C_OP_SLTI: ctrl_d.alu_op = 2'b01;
          default:   ctrl_d.alu_op = 2'b11;
        endcase
      end
      S_ALU_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = (opcode == C_OP_RTYPE);
        ctrl_d.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = 2'b10;
        ctrl_d.alu_funct_src = 2'b10;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = 2'b01;
        ctrl_d.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.pc_source  = 2'b10;
        ctrl_d.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl_d.illegal = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // State and registered control word; reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Handshake-qualified strobes; IDLE during reset keeps them low
  assign w_fetch_ack = (state_q == S_FETCH) && mem_ready;
  assign w_store_ack = (state_q == S_MEM_WRITE) && mem_ready;

  assign pc_write      = ctrl_q.pc_write | w_fetch_ack;
  assign ir_write      = w_fetch_ack;
  assign instr_done    = ctrl_q.instr_done | w_store_ack;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign reg_write     = ctrl_q.reg_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign alu_funct_src = ctrl_q.alu_funct_src;
  assign pc_source     = ctrl_q.pc_source;
  assign illegal       = ctrl_q.illegal;
  assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control; random
//               instruction stream with random memory stalls against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3,
                 ST_MEM_READ = 4, ST_MEM_WB = 5, ST_MEM_WRITE = 6,
                 ST_R_EXEC = 7, ST_ALU_WB = 8, ST_I_EXEC = 9, ST_BRANCH = 10,
                 ST_JUMP = 11, ST_ILLEGAL = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, alu_op, alu_funct_src, pc_source;
  logic [3:0] state;
  logic [19:0] obs;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .alu_funct_src (alu_funct_src),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal       (illegal),
    .state         (state)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                alu_funct_src, pc_source, instr_done, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected control word for a state, straight from the per-state table
  function automatic logic [19:0] exp_out(input int st, input logic [5:0] op, input bit mr);
    logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
    logic [1:0] sb = 0, ao = 0, fs = 0, ps = 0;
    logic dn = 0, il = 0;
    case (st)
      ST_FETCH:     begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      ST_DECODE:    begin sb = 2'b11; end
      ST_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
      ST_MEM_READ:  begin mrd = 1; iod = 1; end
      ST_MEM_WB:    begin rw = 1; m2r = 1; dn = 1; end
      ST_MEM_WRITE: begin mwr = 1; iod = 1; dn = mr; end
      ST_R_EXEC:    begin sa = 1; ao = 2'b10; end
      ST_I_EXEC:    begin
        sa = 1; sb = 2'b10; fs = 2'b01;
        ao = (op == 6'b001000) ? 2'b00 : (op == 6'b001010) ? 2'b01 : 2'b11;
      end
      ST_ALU_WB:    begin rw = 1; rd = (op == 6'b000000); dn = 1; end
      ST_BRANCH:    begin sa = 1; ao = 2'b10; fs = 2'b10; pwc = 1; ps = 2'b01; dn = 1; end
      ST_JUMP:      begin pw = 1; ps = 2'b10; dn = 1; end
      ST_ILLEGAL:   begin il = 1; end
      default:      ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, rw, rd, m2r, sa, sb, ao, fs, ps, dn, il};
  endfunction

  // Cycles from fetch start to retirement with no stalls
  function automatic int base_latency(input logic [5:0] op);
    if (op == 6'b100011) return 5;
    if (op == 6'b000100 || op == 6'b000010) return 3;
    return 4;
  endfunction

  // Runs one legal instruction starting in FETCH (called at posedge+1)
  task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
    int  seq[$];
    bit  mr[$];
    int  cyc = 0;
    int  done_cnt = 0;
    bit  seen = 0;
    int  sm_eff = 0;
    for (int i = 0; i < sf; i++) begin seq.push_back(ST_FETCH); mr.push_back(0); end
    seq.push_back(ST_FETCH); mr.push_back(1);
    seq.push_back(ST_DECODE); mr.push_back(1'($urandom_range(0, 1)));
    case (op)
      6'b100011: begin
        seq.push_back(ST_MEM_ADDR); mr.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < sm; i++) begin seq.push_back(ST_MEM_READ); mr.push_back(0); end
        seq.push_back(ST_MEM_READ); mr.push_back(1);
        seq.push_back(ST_MEM_WB); mr.push_back(1'($urandom_range(0, 1)));
        sm_eff = sm;
      end
      6'b101011: begin
        seq.push_back(ST_MEM_ADDR); mr.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < sm; i++) begin seq.push_back(ST_MEM_WRITE); mr.push_back(0); end
        seq.push_back(ST_MEM_WRITE); mr.push_back(1);
        sm_eff = sm;
      end
      6'b000000: begin
        seq.push_back(ST_R_EXEC); mr.push_back(1'($urandom_range(0, 1)));
        seq.push_back(ST_ALU_WB); mr.push_back(1'($urandom_range(0, 1)));
      end
      6'b000100: begin seq.push_back(ST_BRANCH); mr.push_back(1'($urandom_range(0, 1))); end
      6'b000010: begin seq.push_back(ST_JUMP);   mr.push_back(1'($urandom_range(0, 1))); end
      default: begin
        seq.push_back(ST_I_EXEC); mr.push_back(1'($urandom_range(0, 1)));
        seq.push_back(ST_ALU_WB); mr.push_back(1'($urandom_range(0, 1)));
      end
    endcase
    opcode = op;
    for (int k = 0; k < seq.size(); k++) begin
      mem_ready = mr[k];
      @(negedge clk);
      check($sformatf("state op=%02h c%0d", op, k), 32'(state), 32'(seq[k]));
      check($sformatf("ctrl op=%02h c%0d", op, k), 32'(obs), 32'(exp_out(seq[k], op, mr[k])));
      check($sformatf("mrd&mwr op=%02h c%0d", op, k), 32'(mem_read & mem_write), 32'd0);
      if (!seen) cyc++;
      if (instr_done) begin done_cnt++; seen = 1; end
      @(posedge clk); #1;
    end
    check($sformatf("latency op=%02h", op), 32'(cyc), 32'(base_latency(op) + sf + sm_eff));
    check($sformatf("done_cnt op=%02h", op), 32'(done_cnt), 32'd1);
  endtask

  logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001010,
                                 6'b001100, 6'b001101, 6'b001110, 6'b000100, 6'b000010};

  initial begin
    rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b0;
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset ctrl", 32'(obs), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after release", 32'(state), 32'(ST_IDLE));
    check("idle ctrl", 32'(obs), 32'd0);
    @(posedge clk); #1;

    // Directed: ADD, LW with two stalls, ORI, SLTI, BEQ, J, SW
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 2);
    run_instr(6'b001101, 0, 0);
    run_instr(6'b001010, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 1, 0);
    run_instr(6'b101011, 0, 1);

    // Random instruction stream with random stalls
    for (int n = 0; n < 60; n++) begin
      run_instr(legal_ops[$urandom_range(0, 9)], int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a MEM_WRITE stall
    opcode = 6'b101011; mem_ready = 1'b1;
    @(posedge clk); #1;                      // DECODE
    @(posedge clk); #1;                      // MEM_ADDR
    mem_ready = 1'b0;
    @(posedge clk); #1;                      // MEM_WRITE, stalled
    @(negedge clk);
    check("sw stall state", 32'(state), 32'(ST_MEM_WRITE));
    check("sw stall mem_write", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst mem_write", 32'(mem_write), 32'd0);
    check("async rst state", 32'(state), 32'(ST_IDLE));
    check("async rst ctrl", 32'(obs), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after sw rst", 32'(state), 32'(ST_IDLE));
    @(posedge clk); #1;
    run_instr(6'b001110, 0, 0);

    // Unsupported opcode: sticky ILLEGAL until reset
    opcode = 6'b111111; mem_ready = 1'b1;
    @(negedge clk);
    check("ill fetch", 32'(state), 32'(ST_FETCH));
    @(posedge clk); #1;
    @(negedge clk);
    check("ill decode", 32'(state), 32'(ST_DECODE));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("ill state c%0d", k), 32'(state), 32'(ST_ILLEGAL));
      check($sformatf("ill ctrl c%0d", k), 32'(obs), 32'(exp_out(ST_ILLEGAL, 6'b111111, mem_ready)));
      check($sformatf("ill done c%0d", k), 32'(instr_done), 32'd0);
    end
    rst_n = 1'b0;
    #1;
    check("ill rst state", 32'(state), 32'd0);
    check("ill rst flag", 32'(illegal), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after ill rst", 32'(state), 32'(ST_IDLE));
    @(posedge clk); #1;
    run_instr(6'b001100, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select. It is the upstream producer of the `alu_op` code and the funct-input selection consumed by the ALU control decoder. It also stalls on a single-signal memory ready handshake.

## Interface
Parameters: none; opcodes and state codes are fixed constants.

Ports:
- `clk` in 1 — rising-edge clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `opcode` in 6 — IR[31:26]; stable from DECODE until instruction end.
- `mem_ready` in 1 — memory completes the current read/write this cycle.
- `pc_write`, `pc_write_cond` out 1 — PC enable; PC enable gated by the ALU zero flag.
- `i_or_d` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 — memory strobes.
- `ir_write` out 1 — IR load enable.
- `reg_write`, `reg_dst`, `mem_to_reg` out 1 — register-file write enable; 1 = rd / 0 = rt; 1 = MDR / 0 = ALUOut.
- `alu_src_a` out 1 — 0 = PC, 1 = A.
- `alu_src_b` out 2 — 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_op` out 2 — 00 add, 01 slt, 10 R-type, 11 bitwise I-type.
- `alu_funct_src` out 2 — ALU-control funct input: 00 = IR funct, 01 = opcode, 10 = const 100010 (SUB).
- `pc_source` out 2 — 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1 — one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1 — sticky flag for an unsupported opcode.
- `state` out 4 — current state, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, ALU_WB=8, I_EXEC=9, BRANCH=10, JUMP=11, ILLEGAL=12.
- Outputs are Moore-style, a function of the registered state, except where noted. Every output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00.
  - `ir_write`=`pc_write`=`mem_ready` (Mealy qualification).
  - Holds while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut). Dispatch on `opcode`:
  - 000000 → R_EXEC
  - 100011 (LW), 101011 (SW) → MEM_ADDR
  - 001000 (ADDI), 001010 (SLTI), 001100 (ANDI), 001101 (ORI), 001110 (XORI) → I_EXEC
  - 000100 (BEQ) → BRANCH
  - 000010 (J) → JUMP
  - any other opcode → ILLEGAL
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Next state is FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`; `instr_done`=`mem_ready`. Then goes to FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, `alu_funct_src`=00. Next state is ALU_WB.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_funct_src`=01. `alu_op` is 00 for ADDI, 01 for SLTI, 11 for ANDI/ORI/XORI. Next state is ALU_WB.
- ALU_WB: `reg_write`=1, `mem_to_reg`=0, `reg_dst`=(opcode==000000), `instr_done`=1. Next state is FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, `alu_funct_src`=10, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1. Next state is FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1. Next state is FETCH.
- ILLEGAL: `illegal` is set and stays set; all other outputs are 0. The FSM stays in ILLEGAL until reset.

## Timing
- While `rst_n`=0: state=IDLE, `illegal`=0, all outputs 0 immediately, asynchronously. This holds even mid-instruction, including while a memory access is pending.
- First FETCH is the cycle after the first rising edge with `rst_n`=1.
- Latency with `mem_ready` tied high:
  - LW 5 cycles; SW, R-type and I-type 4 cycles.
  - BEQ and J 3 cycles.
- Each memory state adds one cycle per `mem_ready`=0 cycle. During a stall, outputs stay constant and no register or PC enable toggles.
- `mem_ready` is sampled only in FETCH, MEM_READ and MEM_WRITE. It is ignored elsewhere.
- `instr_done` is exactly one cycle per retired instruction. It is never asserted in IDLE or ILLEGAL.
- `mem_read` and `mem_write` are never both 1. `reg_write` and `mem_write` are never both 1.

## Test plan
- Reset, then an ADD (opcode 000000), `mem_ready`=1: state sequence 0,1,2,7,8,1. In R_EXEC: `alu_op`=10, `alu_funct_src`=00. In ALU_WB: `reg_dst`=1, `instr_done`=1.
- LW with `mem_ready` low for 2 cycles in MEM_READ: 7 cycles total. MEM_READ lasts 3 cycles with `mem_read`=1 and `i_or_d`=1 throughout. MEM_WB has `mem_to_reg`=1.
- ORI (001101) then SLTI (001010): in I_EXEC, `alu_op`=11 then 01, both with `alu_funct_src`=01. In ALU_WB, `reg_dst`=0.
- BEQ: BRANCH has `pc_write_cond`=1, `pc_source`=01, `alu_funct_src`=10. Back to FETCH after 3 cycles.
- Opcode 111111: goes to ILLEGAL (12) with `illegal`=1. Stays there for 10 cycles with no `instr_done`. `rst_n` pulse clears it.
- `rst_n` asserted during a MEM_WRITE stall: `mem_write` drops to 0 in the same cycle, state=0, and the FSM resumes with FETCH after release.
